iq_out_fifo_afull: RTL and testbench

Downstream buffer stage for the interpolated I/Q stream.
- Captures I/Q sample pairs in lockstep on the interpolator's write-enable strobe.
- Returns almost-full back-pressure to the interpolator's Afull_I_in/Afull_Q_in inputs.
- Delivers buffered pairs to the DAC/packetizer side on a registered read handshake.
- I and Q share one pointer set, so the two channels can never desynchronise.

---
 rtl/iq_out_fifo_afull_pkg.sv | 18 +
 rtl/iq_fifo_mem.sv | 41 ++++
 rtl/iq_out_fifo_afull.sv | 120 ++++++++++++
 tb/tb_iq_out_fifo_afull.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_out_fifo_afull_pkg.sv
// Shared constants and types for the I/Q output FIFO.
package iq_out_fifo_afull_pkg;

    localparam int DATAPATH_WIDTH_DEF = 32;
    localparam int DEPTH_LOG2_DEF     = 4;
    localparam int DEPTH_DEF          = 1 << DEPTH_LOG2_DEF;
    localparam int CNT_W_DEF          = DEPTH_LOG2_DEF + 1;

    typedef struct packed {
        logic [DATAPATH_WIDTH_DEF-1:0] i;
        logic [DATAPATH_WIDTH_DEF-1:0] q;
    } iq_pair_t;

    function automatic int depth_of(input int log2);
        return 1 << log2;
    endfunction

endpackage

// File: rtl/iq_fifo_mem.sv
// Simple dual-port pair RAM: synchronous write, registered read.
module iq_fifo_mem
    import iq_out_fifo_afull_pkg::*;
#(
    parameter int W  = 2 * DATAPATH_WIDTH_DEF,
    parameter int AW = DEPTH_LOG2_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int DEPTH = depth_of(AW);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_d;
    logic [W-1:0] rd_data_q;

    // Array is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/iq_out_fifo_afull.sv
// I/Q output FIFO with almost-full back-pressure and sticky overflow.
// Optional high-water mark output enabled by IQ_OUT_FIFO_HWM_EN.
module iq_out_fifo_afull
    import iq_out_fifo_afull_pkg::*;
#(
    parameter int DATAPATH_WIDTH = DATAPATH_WIDTH_DEF,
    parameter int DEPTH_LOG2     = DEPTH_LOG2_DEF,
    parameter int AFULL_MARGIN   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Write_enable_i,
    input  logic [DATAPATH_WIDTH-1:0] I_in,
    input  logic [DATAPATH_WIDTH-1:0] Q_in,
    output logic                      Afull_I_o,
    output logic                      Afull_Q_o,
    input  logic                      rd_en_i,
    output logic [DATAPATH_WIDTH-1:0] I_out,
    output logic [DATAPATH_WIDTH-1:0] Q_out,
    output logic                      valid_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [DEPTH_LOG2:0]       count_o,
    output logic                      overflow_o
`ifdef IQ_OUT_FIFO_HWM_EN
    ,
    output logic [DEPTH_LOG2:0]       hwm_o
`endif
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = 2 * DATAPATH_WIDTH;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_THR = CW'(DEPTH - AFULL_MARGIN);

    logic [DEPTH_LOG2-1:0] wr_ptr_d, wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0]         count_d, count_q;
    logic                  valid_d, valid_q;
    logic                  overflow_d, overflow_q;
    logic                  wr_ok, rd_ok;
    logic [PW-1:0]         rd_data;

    always_comb begin
        rd_ok      = rd_en_i & (count_q != '0);
        // A read in the same cycle frees the slot the write needs.
        wr_ok      = Write_enable_i & ((count_q != FULL_CNT) | rd_ok);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = rd_ok;
        overflow_d = overflow_q | (Write_enable_i & ~wr_ok);
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    iq_fifo_mem #(
        .W  (PW),
        .AW (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data ({I_in, Q_in}),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign I_out      = rd_data[PW-1:DATAPATH_WIDTH];
    assign Q_out      = rd_data[DATAPATH_WIDTH-1:0];
    assign valid_o    = valid_q;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign Afull_I_o  = (count_q >= AFULL_THR);
    assign Afull_Q_o  = Afull_I_o;
    assign overflow_o = overflow_q;

`ifdef IQ_OUT_FIFO_HWM_EN
    logic [CW-1:0] hwm_d, hwm_q;

    always_comb begin
        hwm_d = hwm_q;
        if (count_q > hwm_q) hwm_d = count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hwm_q <= '0;
        else      hwm_q <= hwm_d;
    end

    assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_iq_out_fifo_afull.sv
// Directed bench for iq_out_fifo_afull: vector table plus corner sequences.
module tb_iq_out_fifo_afull;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] di, dq;
    logic        rd;
    logic        afull_i, afull_q;
    logic [31:0] iout, qout;
    logic        valid, empty, full, ovf;
    logic [4:0]  cnt;
`ifdef IQ_OUT_FIFO_HWM_EN
    logic [4:0]  hwm;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iq_out_fifo_afull dut (
        .clk            (clk),
        .rst            (rst),
        .Write_enable_i (we),
        .I_in           (di),
        .Q_in           (dq),
        .Afull_I_o      (afull_i),
        .Afull_Q_o      (afull_q),
        .rd_en_i        (rd),
        .I_out          (iout),
        .Q_out          (qout),
        .valid_o        (valid),
        .empty_o        (empty),
        .full_o         (full),
        .count_o        (cnt),
        .overflow_o     (ovf)
`ifdef IQ_OUT_FIFO_HWM_EN
        ,
        .hwm_o          (hwm)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] di;
        logic [31:0] dq;
        logic        rd;
        logic [4:0]  e_cnt;
        logic        e_afull;
        logic        e_valid;
        logic [31:0] e_i;
        logic [31:0] e_q;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[34];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [31:0] i,
                       input logic [31:0] q, input logic r);
        we = w;
        di = i;
        dq = q;
        rd = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        we  = 1'b0;
        rd  = 1'b0;
        #2;
        rst = 1'b1;
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        int k;
        int wr_n;
        int rd_n;
        int n;
        logic done;
        logic exp_v;
        logic [31:0] exp_i, exp_q;
        logic [31:0] mq_i[$];
        logic [31:0] mq_q[$];

        // Table: 16 writes, dropped write, 16 reads, one idle.
        for (int j = 1; j <= 16; j++) begin
            vecs[j-1] = '{1'b1, 32'(j), ~32'(j), 1'b0, 5'(j), j >= 12,
                          1'b0, 32'h0, 32'h0, j == 16, 1'b0};
        end
        vecs[16] = '{1'b1, 32'hDEAD, 32'hDEAD, 1'b0, 5'd16, 1'b1,
                     1'b0, 32'h0, 32'h0, 1'b1, 1'b1};
        for (int j = 1; j <= 16; j++) begin
            vecs[16+j] = '{1'b0, 32'h0, 32'h0, 1'b1, 5'(16 - j),
                           (16 - j) >= 12, 1'b1, 32'(j), ~32'(j),
                           1'b0, 1'b1};
        end
        vecs[33] = '{1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0,
                     32'd16, ~32'd16, 1'b0, 1'b1};

        rst = 1'b0;
        we  = 1'b0;
        rd  = 1'b0;
        di  = '0;
        dq  = '0;
        @(posedge clk);
        #1;
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_iout", iout, 0);
        chk("rst_afull", 32'(afull_i), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 34; i++) begin
            cyc(vecs[i].we, vecs[i].di, vecs[i].dq, vecs[i].rd);
            chk($sformatf("v%0d_cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_afi", i), 32'(afull_i),
                32'(vecs[i].e_afull));
            chk($sformatf("v%0d_afq", i), 32'(afull_q),
                32'(vecs[i].e_afull));
            chk($sformatf("v%0d_val", i), 32'(valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d_emp", i), 32'(empty),
                32'(vecs[i].e_cnt == 0));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
            if (i >= 17) begin
                chk($sformatf("v%0d_i", i), iout, vecs[i].e_i);
                chk($sformatf("v%0d_q", i), qout, vecs[i].e_q);
            end
        end
`ifdef IQ_OUT_FIFO_HWM_EN
        chk("hwm_peak", 32'(hwm), 16);
`endif

        // Full FIFO with simultaneous read and write.
        do_reset();
        for (int j = 0; j < 16; j++) cyc(1, 32'(100 + j), 32'(500 + j), 0);
        chk("fw_full", 32'(full), 1);
        cyc(1, 32'h200, 32'h300, 1);
        chk("fw_cnt", 32'(cnt), 16);
        chk("fw_val", 32'(valid), 1);
        chk("fw_i", iout, 100);
        chk("fw_q", qout, 500);
        chk("fw_ovf", 32'(ovf), 0);
        for (int j = 1; j < 16; j++) begin
            cyc(0, 0, 0, 1);
            chk($sformatf("fw_r%0d", j), iout, 32'(100 + j));
        end
        cyc(0, 0, 0, 1);
        chk("fw_last_i", iout, 32'h200);
        chk("fw_last_q", qout, 32'h300);
        chk("fw_last_cnt", 32'(cnt), 0);

        // Empty FIFO with simultaneous read and write: no fall-through.
        do_reset();
        cyc(1, 32'h5, 32'hA, 1);
        chk("ew_val", 32'(valid), 0);
        chk("ew_cnt", 32'(cnt), 1);
        cyc(0, 0, 0, 1);
        chk("ew_val2", 32'(valid), 1);
        chk("ew_i", iout, 32'h5);
        chk("ew_q", qout, 32'hA);
        chk("ew_cnt2", 32'(cnt), 0);
        cyc(0, 0, 0, 0);
        chk("ew_val3", 32'(valid), 0);
        chk("ew_hold", iout, 32'h5);

        // Interleaved traffic against a queue model; 40 pairs wrap twice.
        do_reset();
        wr_n = 0;
        rd_n = 0;
        done = 1'b0;
        n    = 0;
        while (!done && n < 3000) begin
            logic w, r;
            n++;
            w = (wr_n < 40) && (mq_i.size() < 16) && ($urandom_range(2) != 0);
            r = $urandom_range(1) != 0;
            exp_v = r && (mq_i.size() > 0);
            if (exp_v) begin
                exp_i = mq_i.pop_front();
                exp_q = mq_q.pop_front();
                rd_n++;
            end
            k = 1000 + wr_n;
            if (w) begin
                mq_i.push_back(32'(k));
                mq_q.push_back(~32'(k * 3));
                wr_n++;
            end
            cyc(w, 32'(k), ~32'(k * 3), r);
            chk("rnd_val", 32'(valid), 32'(exp_v));
            if (exp_v) begin
                chk("rnd_i", iout, exp_i);
                chk("rnd_q", qout, exp_q);
            end
            chk("rnd_cnt", 32'(cnt), 32'(mq_i.size()));
            if (wr_n == 40 && mq_i.size() == 0) done = 1'b1;
        end
        chk("rnd_done", 32'(done), 1);
        chk("rnd_reads", 32'(rd_n), 40);
        chk("rnd_ovf", 32'(ovf), 0);

        // Asynchronous reset mid-stream.
        do_reset();
        for (int j = 0; j < 7; j++) cyc(1, 32'(j), 32'(j), 0);
        cyc(0, 0, 0, 0);
        chk("ar_pre", 32'(cnt), 7);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cnt", 32'(cnt), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_afull", 32'(afull_i), 0);
        chk("ar_ovf", 32'(ovf), 0);
`ifdef IQ_OUT_FIFO_HWM_EN
        chk("ar_hwm", 32'(hwm), 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 32'h77, 32'h88, 0);
        chk("ar_cnt1", 32'(cnt), 1);
        cyc(0, 0, 0, 1);
        chk("ar_val", 32'(valid), 1);
        chk("ar_i", iout, 32'h77);
        chk("ar_q", qout, 32'h88);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
